spi_master_param: RTL and testbench

SPI_MASTER_PARAM -- requirements
Module: spi_master_param

---
 rtl/spi_pkg.sv | 30 +++
 rtl/spi_clkgen.sv | 44 ++++
 rtl/spi_master_param.sv | 211 +++++++++++++++++++++
 tb/tb_spi_master_param.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and defaults for the parameterised SPI master: FSM states,
// fill-mode encodings and default parameter values.
package spi_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_N_CS   = 1;
  localparam int DEF_DIV_W  = 8;
  localparam int DEF_CNT_W  = 9;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_NEXT  = 3'd3,
    ST_HOLD  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    FILL_DATA  = 2'b00,
    FILL_ONES  = 2'b01,
    FILL_ZEROS = 2'b10,
    FILL_RSVD  = 2'b11
  } fill_e;

  // The reserved fill code behaves exactly like normal data mode.
  function automatic logic is_data_mode(input logic [1:0] fill);
    return (fill == FILL_DATA) || (fill == FILL_RSVD);
  endfunction

endpackage

// File: rtl/spi_clkgen.sv
// Half-period divider for the SPI master: tick every div+1 cycles while running,
// split into leading/trailing sclk edge strobes while shifting.
module spi_clkgen
  import spi_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_i,
  input  logic             shift_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o,
  output logic             lead_o,
  output logic             trail_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             ph_q, ph_d;

  assign tick_o  = run_i && (cnt_q == div_i);
  assign lead_o  = tick_o && shift_i && !ph_q;
  assign trail_o = tick_o && shift_i && ph_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cnt_d = '0;
    ph_d  = 1'b0;
    if (run_i && !tick_o) cnt_d = cnt_q + DIV_W'(1);
    if (shift_i)          ph_d  = tick_o ? !ph_q : ph_q;
  end

  // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      ph_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ph_q  <= ph_d;
    end
  end

endmodule

// File: rtl/spi_master_param.sv
// Parameterised SPI master: burst of n_words words, selectable CPOL/CPHA,
// fill modes, one-hot-low chip selects and a programmable sclk divider.
module spi_master_param
  import spi_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int N_CS   = DEF_N_CS,
  parameter int DIV_W  = DEF_DIV_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  input  logic                                        start_i,
  input  logic                                        cpol_i,
  input  logic                                        cpha_i,
  input  logic [DIV_W-1:0]                            div_i,
  input  logic [((N_CS > 1) ? $clog2(N_CS) : 1)-1:0]  cs_sel_i,
  input  logic [CNT_W-1:0]                            n_words_i,
  input  logic [1:0]                                  fill_i,
  input  logic [DATA_W-1:0]                           tx_data_i,
  input  logic                                        tx_valid_i,
  output logic                                        tx_ready_o,
  output logic [DATA_W-1:0]                           rx_data_o,
  output logic                                        rx_valid_o,
  input  logic                                        miso_i,
  output logic                                        mosi_o,
  output logic                                        sclk_o,
  output logic [N_CS-1:0]                             cs_n_o,
  output logic                                        busy_o,
  output logic                                        done_o,
  output logic [CNT_W-1:0]                            words_done_o
);

  localparam int CS_W = (N_CS > 1) ? $clog2(N_CS) : 1;
  localparam int BC_W = $clog2(DATA_W + 1);
  localparam logic [BC_W-1:0] BITS_LAST = BC_W'(DATA_W - 1);
  localparam logic [BC_W-1:0] BITS_FULL = BC_W'(DATA_W);

  // Out-of-range selects match no index, leaving every chip select high.
  function automatic logic [N_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
    cs_decode = '1;
    for (int i = 0; i < N_CS; i++)
      if (sel == CS_W'(i)) cs_decode[i] = 1'b0;
  endfunction

  state_e               state_q;
  fill_e                fill_q;
  logic                 cpol_q, cpha_q;
  logic [DIV_W-1:0]     div_q;
  logic [CNT_W-1:0]     n_words_q, words_done_q, n_eff;
  logic [N_CS-1:0]      cs_n_q;
  logic                 sclk_q, mosi_q, busy_q, done_q, rx_valid_q, tx_ready_q;
  logic [DATA_W-1:0]    rx_data_q, tx_sh_q, load_word;
  logic [DATA_W-2:0]    rx_sh_q;
  logic [BC_W-1:0]      bit_cnt_q;
  logic                 loaded_q, run_q, shift_en_q;
  logic                 tick, lead, trail, sample, shift_out, word_end;

  spi_clkgen #(.DIV_W(DIV_W)) u_clkgen (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .run_i   (run_q),
    .shift_i (shift_en_q),
    .div_i   (div_q),
    .tick_o  (tick),
    .lead_o  (lead),
    .trail_o (trail)
  );

  always_comb begin
    load_word = tx_data_i;
    case (fill_q)
      FILL_ONES:  load_word = '1;
      FILL_ZEROS: load_word = '0;
      default:    load_word = tx_data_i;
    endcase
  end

  assign n_eff     = (n_words_q == '0) ? CNT_W'(1) : n_words_q;
  assign sample    = cpha_q ? trail : lead;
  // With cpha=0 the first bit is presented at load, so the final trailing edge shifts nothing.
  assign shift_out = cpha_q ? lead : (trail && (bit_cnt_q != BITS_FULL));
  assign word_end  = trail && (bit_cnt_q == (cpha_q ? BITS_LAST : BITS_FULL));

  // NOTE: the shift registers are reset along with control state so rx_data_o reads 0 after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      fill_q       <= FILL_DATA;
      cpol_q       <= 1'b0;
      cpha_q       <= 1'b0;
      div_q        <= '0;
      n_words_q    <= '0;
      words_done_q <= '0;
      cs_n_q       <= '1;
      sclk_q       <= 1'b0;
      mosi_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rx_valid_q   <= 1'b0;
      tx_ready_q   <= 1'b0;
      rx_data_q    <= '0;
      tx_sh_q      <= '0;
      rx_sh_q      <= '0;
      bit_cnt_q    <= '0;
      loaded_q     <= 1'b0;
      run_q        <= 1'b0;
      shift_en_q   <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          busy_q <= 1'b0;
          sclk_q <= cpol_q;
          if (start_i && !busy_q) begin
            cpol_q       <= cpol_i;
            cpha_q       <= cpha_i;
            div_q        <= div_i;
            n_words_q    <= n_words_i;
            fill_q       <= fill_e'(fill_i);
            sclk_q       <= cpol_i;
            cs_n_q       <= cs_decode(cs_sel_i);
            words_done_q <= '0;
            busy_q       <= 1'b1;
            loaded_q     <= 1'b0;
            tx_ready_q   <= is_data_mode(fill_i);
            state_q      <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (!loaded_q) begin
            if (!is_data_mode(fill_q) || (tx_valid_i && tx_ready_q)) begin
              tx_ready_q <= 1'b0;
              loaded_q   <= 1'b1;
              run_q      <= 1'b1;
              bit_cnt_q  <= '0;
              if (cpha_q) begin
                tx_sh_q <= load_word;
              end else begin
                mosi_q  <= load_word[DATA_W-1];
                tx_sh_q <= {load_word[DATA_W-2:0], 1'b0};
              end
            end
          end else if (tick) begin
            shift_en_q <= 1'b1;
            state_q    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (lead || trail) sclk_q <= !sclk_q;
          if (sample) begin
            rx_sh_q   <= {rx_sh_q[DATA_W-3:0], miso_i};
            bit_cnt_q <= bit_cnt_q + BC_W'(1);
            if (bit_cnt_q == BITS_LAST) begin
              rx_data_q    <= {rx_sh_q, miso_i};
              rx_valid_q   <= 1'b1;
              words_done_q <= words_done_q + CNT_W'(1);
            end
          end
          if (shift_out) begin
            mosi_q  <= tx_sh_q[DATA_W-1];
            tx_sh_q <= {tx_sh_q[DATA_W-2:0], 1'b0};
          end
          if (word_end) begin
            run_q      <= 1'b0;
            shift_en_q <= 1'b0;
            state_q    <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (words_done_q < n_eff) begin
            loaded_q   <= 1'b0;
            tx_ready_q <= is_data_mode(fill_q);
            state_q    <= ST_SETUP;
          end else begin
            run_q   <= 1'b1;
            state_q <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (tick) begin
            run_q   <= 1'b0;
            cs_n_q  <= '1;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          run_q      <= 1'b0;
          shift_en_q <= 1'b0;
          tx_ready_q <= 1'b0;
          cs_n_q     <= '1;
          busy_q     <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_ready_o   = tx_ready_q;
  assign rx_data_o    = rx_data_q;
  assign rx_valid_o   = rx_valid_q;
  assign mosi_o       = mosi_q;
  assign sclk_o       = sclk_q;
  assign cs_n_o       = cs_n_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign words_done_o = words_done_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param: SPI modes, multi-word stall, fill modes,
// chip-select decode and mid-word reset, with an edge monitor acting as the slave.
module tb_spi_master_param;

  logic        clk = 1'b0;
  logic        rst, start, cpol, cpha, tx_valid;
  logic [7:0]  div, tx_data;
  logic [1:0]  cs_sel, fill;
  logic [8:0]  n_words;
  logic        miso, loop_en, miso_tie;
  logic        tx_ready, rx_valid, mosi, sclk, busy, done;
  logic [7:0]  rx_data;
  logic [3:0]  cs_n;
  logic [8:0]  words_done;

  logic        b_tx_ready, b_rx_valid, b_mosi, b_sclk, b_busy, b_done;
  logic [7:0]  b_rx_data;
  logic [2:0]  b_cs_n;
  logic [8:0]  b_words_done;
  localparam logic [1:0] SEL_B = 2'd3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;
  assign miso = loop_en ? mosi : miso_tie;

  spi_master_param #(.DATA_W(8), .N_CS(4), .DIV_W(8), .CNT_W(9)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .cpol_i(cpol), .cpha_i(cpha),
    .div_i(div), .cs_sel_i(cs_sel), .n_words_i(n_words), .fill_i(fill),
    .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
    .rx_data_o(rx_data), .rx_valid_o(rx_valid), .miso_i(miso), .mosi_o(mosi),
    .sclk_o(sclk), .cs_n_o(cs_n), .busy_o(busy), .done_o(done),
    .words_done_o(words_done)
  );

  // Second instance with three chip selects, driven with an out-of-range select.
  spi_master_param #(.DATA_W(8), .N_CS(3), .DIV_W(8), .CNT_W(9)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start), .cpol_i(cpol), .cpha_i(cpha),
    .div_i(div), .cs_sel_i(SEL_B), .n_words_i(n_words), .fill_i(fill),
    .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(b_tx_ready),
    .rx_data_o(b_rx_data), .rx_valid_o(b_rx_valid), .miso_i(miso), .mosi_o(b_mosi),
    .sclk_o(b_sclk), .cs_n_o(b_cs_n), .busy_o(b_busy), .done_o(b_done),
    .words_done_o(b_words_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave-side monitor; statistics restart whenever busy_o rises.
  logic        mon_cpol = 1'b0, mon_cpha = 1'b0;
  logic        sclk_prev = 1'b0, busy_prev = 1'b0, have_lead = 1'b0, rdy_seen = 1'b0;
  logic [31:0] cap = '0;
  logic [3:0]  cs_and = '1, cs_or = '0;
  logic [2:0]  csb_and = '1, csb_or = '0;
  int cyc = 0, last_lead = 0, leads = 0, rxv_n = 0, done_n = 0, per_min = 0, per_max = 0;

  always @(negedge clk) begin
    cyc       <= cyc + 1;
    sclk_prev <= sclk;
    busy_prev <= busy;
    if (busy && !busy_prev) begin
      leads <= 0; cap <= '0; rxv_n <= 0; done_n <= 0; have_lead <= 1'b0;
      per_min <= 1000; per_max <= 0; rdy_seen <= tx_ready;
      cs_and <= cs_n; cs_or <= cs_n; csb_and <= b_cs_n; csb_or <= b_cs_n;
    end else begin
      if (rx_valid) rxv_n <= rxv_n + 1;
      if (done) done_n <= done_n + 1;
      if (tx_ready) rdy_seen <= 1'b1;
      if (busy && !done) begin
        cs_and <= cs_and & cs_n;  cs_or <= cs_or | cs_n;
        csb_and <= csb_and & b_cs_n; csb_or <= csb_or | b_cs_n;
      end
      if (sclk != sclk_prev) begin
        if (sclk != mon_cpol) begin
          leads     <= leads + 1;
          last_lead <= cyc;
          have_lead <= 1'b1;
          if (have_lead) begin
            if (cyc - last_lead < per_min) per_min <= cyc - last_lead;
            if (cyc - last_lead > per_max) per_max <= cyc - last_lead;
          end
          if (!mon_cpha) cap <= {cap[30:0], mosi};
        end else if (mon_cpha) begin
          cap <= {cap[30:0], mosi};
        end
      end
    end
  end

  function automatic logic [7:0] word_at(input logic [23:0] w, input int i);
    return w[23-8*i -: 8];
  endfunction

  // Runs one burst, serving tx handshakes; optional 20-cycle stall before word 2.
  task automatic burst(input logic c_pol, input logic c_pha, input logic [7:0] c_div,
                       input logic [1:0] sel, input logic [8:0] nw, input logic [1:0] fl,
                       input logic [23:0] words, input logic [3:0] exp_cs, input bit stall);
    int  idx, n_eff, errs;
    bit  hs, fin, stalled, dmode;
    n_eff = (nw == 0) ? 1 : int'(nw);
    dmode = (fl == 2'b00) || (fl == 2'b11);
    mon_cpol = c_pol; mon_cpha = c_pha;
    cpol = c_pol; cpha = c_pha; div = c_div; cs_sel = sel; n_words = nw; fill = fl;
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    idx      = 0;
    tx_data  = word_at(words, 0);
    tx_valid = dmode;
    fin = 1'b0; stalled = 1'b0;
    for (int c = 0; c < 3000 && !fin; c++) begin
      hs = tx_valid && tx_ready;
      @(negedge clk);
      if (done) fin = 1'b1;
      if (hs) begin
        idx++;
        tx_valid = 1'b0;
        if (idx < n_eff && !(stall && idx == 1)) begin
          tx_data  = word_at(words, idx);
          tx_valid = 1'b1;
        end
      end
      if (stall && idx == 1 && !stalled && tx_ready) begin
        stalled = 1'b1;
        errs    = 0;
        repeat (20) begin
          @(negedge clk);
          if (sclk !== c_pol || cs_n !== exp_cs) errs++;
        end
        check("stall_idle", errs, 0);
        tx_data  = word_at(words, 1);
        tx_valid = 1'b1;
      end
    end
    tx_valid = 1'b0;
    check("burst_done", fin, 1);
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; cpol = 1'b0; cpha = 1'b0; tx_valid = 1'b0;
    div = 8'd1; tx_data = '0; cs_sel = '0; fill = '0; n_words = 9'd1;
    loop_en = 1'b1; miso_tie = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cs_n", cs_n, 4'hF);
    check("rst_idle_bus", {sclk, mosi, busy, done, rx_valid, tx_ready}, 6'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_words_done", words_done, 9'd0);
    rst = 1'b0;
    @(negedge clk);

    // Mode 0, div=1 -> 4-cycle sclk period, chip select 2 of 4.
    burst(1'b0, 1'b0, 8'd1, 2'd2, 9'd1, 2'b00, 24'hA5_00_00, 4'b1011, 1'b0);
    check("m0_rx_data", rx_data, 8'hA5);
    check("m0_mosi_bits", cap[7:0], 8'hA5);
    check("m0_sclk_periods", leads, 8);
    check("m0_period_min", per_min, 4);
    check("m0_period_max", per_max, 4);
    check("m0_done_pulses", done_n, 1);
    check("m0_rx_valid_pulses", rxv_n, 1);
    check("m0_words_done", words_done, 9'd1);
    check("m0_cs_and", cs_and, 4'b1011);
    check("m0_cs_or", cs_or, 4'b1011);
    check("m0_idle_after", {busy, sclk, cs_n}, {1'b0, 1'b0, 4'hF});
    check("oor_cs_and", csb_and, 3'b111);
    check("oor_cs_or", csb_or, 3'b111);
    check("oor_rx_data", b_rx_data, 8'hA5);
    check("oor_words_done", b_words_done, 9'd1);
    check("oor_idle_bus", {b_busy, b_done, b_rx_valid, b_tx_ready, b_sclk, b_mosi}, 6'b000001);

    // Mode 1: div=0, period 2, cs 1.
    burst(1'b0, 1'b1, 8'd0, 2'd1, 9'd1, 2'b00, 24'h3C_00_00, 4'b1101, 1'b0);
    check("m1_rx_data", rx_data, 8'h3C);
    check("m1_mosi_bits", cap[7:0], 8'h3C);
    check("m1_period", per_min, 2);
    check("m1_sclk_idle", sclk, 1'b0);
    check("m1_cs", cs_and, 4'b1101);
    // Mode 2: div=2, period 6, cs 3.
    burst(1'b1, 1'b0, 8'd2, 2'd3, 9'd1, 2'b00, 24'h3C_00_00, 4'b0111, 1'b0);
    check("m2_rx_data", rx_data, 8'h3C);
    check("m2_mosi_bits", cap[7:0], 8'h3C);
    check("m2_period", per_max, 6);
    check("m2_sclk_idle", sclk, 1'b1);
    check("m2_sclk_count", leads, 8);
    // Mode 3: div=1, period 4, cs 0.
    burst(1'b1, 1'b1, 8'd1, 2'd0, 9'd1, 2'b00, 24'h3C_00_00, 4'b1110, 1'b0);
    check("m3_rx_data", rx_data, 8'h3C);
    check("m3_mosi_bits", cap[7:0], 8'h3C);
    check("m3_period", per_min, 4);
    check("m3_sclk_idle", sclk, 1'b1);

    // Three words with the second word withheld for 20 cycles.
    burst(1'b0, 1'b0, 8'd1, 2'd0, 9'd3, 2'b00, 24'h5A_C3_81, 4'b1110, 1'b1);
    check("mw_rx_valid_pulses", rxv_n, 3);
    check("mw_words_done", words_done, 9'd3);
    check("mw_rx_data", rx_data, 8'h81);
    check("mw_mosi_bits", cap[23:0], 24'h5AC381);
    check("mw_done_pulses", done_n, 1);
    check("mw_cs_const", {cs_and, cs_or}, {4'b1110, 4'b1110});

    // Fill all ones, miso tied low: tx_ready never asserted.
    loop_en = 1'b0; miso_tie = 1'b0;
    burst(1'b0, 1'b0, 8'd0, 2'd1, 9'd1, 2'b01, 24'h00_00_00, 4'b1101, 1'b0);
    check("f1_mosi_bits", cap[7:0], 8'hFF);
    check("f1_tx_ready_seen", rdy_seen, 1'b0);
    check("f1_rx_data", rx_data, 8'h00);
    check("f1_rx_valid_pulses", rxv_n, 1);

    // Fill zeros with n_words=0 (one word), miso tied high.
    miso_tie = 1'b1;
    burst(1'b0, 1'b1, 8'd1, 2'd2, 9'd0, 2'b10, 24'h00_00_00, 4'b1011, 1'b0);
    check("f0_mosi_bits", cap[7:0], 8'h00);
    check("f0_rx_data", rx_data, 8'hFF);
    check("f0_words_done", words_done, 9'd1);
    check("f0_rx_valid_pulses", rxv_n, 1);
    loop_en = 1'b1;

    // Reset in the middle of bit 4 of a mode-2 word.
    mon_cpol = 1'b1; mon_cpha = 1'b0;
    cpol = 1'b1; cpha = 1'b0; div = 8'd1; cs_sel = 2'd1; n_words = 9'd1; fill = 2'b00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; tx_data = 8'hA5; tx_valid = 1'b1;
    for (int c = 0; c < 500 && leads < 4; c++) @(negedge clk);
    check("rst_reach_bit4", leads >= 4, 1'b1);
    repeat (2) @(negedge clk);
    check("rst_pre_sclk", sclk, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; tx_valid = 1'b0;
    check("abort_cs_n", cs_n, 4'hF);
    check("abort_bus", {sclk, mosi, busy, done, rx_valid, tx_ready}, 6'b0);
    check("abort_rx_data", rx_data, 8'h00);
    check("abort_words_done", words_done, 9'd0);
    repeat (40) @(negedge clk);
    check("abort_no_done", done_n, 0);
    check("abort_no_rx_valid", rxv_n, 0);
    check("abort_sclk_low", sclk, 1'b0);

    // Reserved fill code behaves as data mode.
    burst(1'b0, 1'b0, 8'd1, 2'd0, 9'd1, 2'b11, 24'h96_00_00, 4'b1110, 1'b0);
    check("rsvd_rx_data", rx_data, 8'h96);
    check("rsvd_done_pulses", done_n, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
